fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit synchronous FIFO. It pops one byte at a time from the FIFO read port and serialises it onto a UART line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the FIFO's dout/empty/rd_en interface and the board TX pin. It owns FIFO read timing, so the FIFO never sees rd_en while empty.

---
 rtl/fifo_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Purpose: drains an 8-bit synchronous FIFO one byte at a time onto a UART TX line (start, 8 data LSB first, optional parity, 1/2 stop).
// Latency: start bit begins 3 edges after IDLE samples en && !fifo_empty (IDLE -> POP -> WAIT -> START); frame length is fixed.
// Backpressure: one byte in flight; the FIFO is popped only from IDLE and never when empty, so the line rate throttles the source.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // Bit-period counter runs 0..CLKS_PER_BIT-1; guard keeps the width legal at the minimum divisor.
  localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_reg_nxt;
  logic          parity, parity_nxt;
  logic          rd_en_nxt;
  logic          tx_nxt;
  logic          busy_nxt;
  logic          frame_done_nxt;
  logic [15:0]   frame_count_nxt;
  logic          clk_last;

  assign clk_last = (clk_cnt == CLK_LAST);

  // State, datapath and every output are registered here; reset takes priority over any transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity      <= 1'b0;
      fifo_rd_en  <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift_reg   <= shift_reg_nxt;
      parity      <= parity_nxt;
      fifo_rd_en  <= rd_en_nxt;
      tx          <= tx_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  // Next-state and next-output decode; tx for the following bit is set on the edge that closes the current one.
  always_comb begin
    state_nxt       = state;
    clk_cnt_nxt     = clk_cnt;
    bit_cnt_nxt     = bit_cnt;
    shift_reg_nxt   = shift_reg;
    parity_nxt      = parity;
    rd_en_nxt       = 1'b0;
    tx_nxt          = tx;
    busy_nxt        = busy;
    frame_done_nxt  = 1'b0;
    frame_count_nxt = frame_count;

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        // en is only honoured here, so dropping it mid-frame lets the frame finish.
        if (en && !fifo_empty) begin
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = S_POP;
        end
      end

      S_POP: begin
        // rd_en was high for this one cycle; the FIFO presents the byte after this edge.
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        shift_reg_nxt = fifo_dout;
        parity_nxt    = PAR_INIT;
        clk_cnt_nxt   = '0;
        bit_cnt_nxt   = '0;
        tx_nxt        = 1'b0;
        state_nxt     = S_START;
      end

      S_START: begin
        if (clk_last) begin
          clk_cnt_nxt = '0;
          tx_nxt      = shift_reg[0];
          state_nxt   = S_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (clk_last) begin
          clk_cnt_nxt   = '0;
          parity_nxt    = parity ^ shift_reg[0];
          shift_reg_nxt = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_nxt = '0;
            if (PARITY_EN != 0) begin
              tx_nxt    = parity ^ shift_reg[0];
              state_nxt = S_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = S_STOP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shift_reg[1];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end

      S_PARITY: begin
        if (clk_last) begin
          clk_cnt_nxt = '0;
          tx_nxt      = 1'b1;
          state_nxt   = S_STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end

      S_STOP: begin
        // bit_cnt counts stop bits here so two stop bits reuse the same divisor.
        if (clk_last) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_nxt     = '0;
            frame_done_nxt  = 1'b1;
            frame_count_nxt = frame_count + 16'd1;
            busy_nxt        = 1'b0;
            state_nxt       = S_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end

      default: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity / even parity / odd parity with two stop bits), each fed by a
// queue-backed FIFO model. Stimulus pushes the hand-computed frame into a scoreboard queue; a per-instance monitor
// reconstructs each frame from the tx line cycle by cycle and compares it, plus frame_done/frame_count/busy.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;   // bit periods in time order, bits[0] = start bit
    int          nbits;
    int          gap;    // required idle-high cycles before this start bit, -1 = unchecked
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en;
  wire  [2:0]  tx_w;
  wire  [2:0]  busy_w;
  wire  [2:0]  fdone_w;
  wire  [2:0]  rd_w;
  wire  [15:0] fc_w [3];

  logic [7:0]  fq [3][$];
  exp_t        eq [3][$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [15:0] bits, input int nbits, input int gap);
    exp_t e;
    e.bits  = bits;
    e.nbits = nbits;
    e.gap   = gap;
    eq[i].push_back(e);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int PE = (g == 0) ? 0 : 1;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 2) ? 2 : 1;

    logic       fempty;
    logic [7:0] fdout;
    logic       prev_rd;
    int         pops;

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO),
      .STOP_BITS   (SB)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en[g]),
      .fifo_empty (fempty),
      .fifo_dout  (fdout),
      .fifo_rd_en (rd_w[g]),
      .tx         (tx_w[g]),
      .busy       (busy_w[g]),
      .frame_done (fdone_w[g]),
      .frame_count(fc_w[g])
    );

    // FIFO read port model: registered dout, pops on each sampled rd_en
    initial begin
      fdout   = 8'h00;
      prev_rd = 1'b0;
      pops    = 0;
      forever begin
        @(posedge clk);
        if (rd_w[g]) begin
          pops++;
          chk("rd_en_width", 64'(prev_rd), 64'd0);
          chk("rd_while_empty", 64'(fq[g].size() == 0), 64'd0);
          if (fq[g].size() != 0) fdout = fq[g].pop_front();
        end
        prev_rd = rd_w[g];
      end
    end

    // FIFO empty flag, refreshed away from the DUT's sampling edge
    initial begin
      fempty = 1'b1;
      forever begin
        @(negedge clk);
        fempty = (fq[g].size() == 0);
      end
    end

    // tx monitor: pops the expected frame at each start bit and compares the whole waveform
    initial begin
      exp_t        e;
      logic [63:0] wave;
      logic [63:0] want;
      logic        aborted;
      logic        busy_ok;
      int          gap;
      logic [15:0] cnt;
      gap = -100;
      cnt = 16'd0;
      forever begin
        @(negedge clk);
        if (!reset) begin
          cnt = 16'd0;
          gap = -100;
        end else if (tx_w[g] == 1'b1) begin
          gap++;
        end else begin
          chk("frame_expected", 64'(eq[g].size() != 0), 64'd1);
          if (eq[g].size() != 0) begin
            e = eq[g].pop_front();
            if (e.gap >= 0) chk("start_gap", 64'(gap), 64'(e.gap));
            wave    = '0;
            want    = '0;
            aborted = 1'b0;
            busy_ok = 1'b1;
            for (int k = 0; k < e.nbits * CPB; k++) want[k] = e.bits[k / CPB];
            for (int k = 0; k < e.nbits * CPB; k++) begin
              if (k > 0) @(negedge clk);
              if (!reset) begin
                aborted = 1'b1;
                break;
              end
              wave[k] = tx_w[g];
              if (!busy_w[g] || fdone_w[g]) busy_ok = 1'b0;
            end
            if (aborted) begin
              eq[g].push_front(e);
              cnt = 16'd0;
              gap = -100;
            end else begin
              chk("frame_wave", wave, want);
              chk("busy_in_frame", 64'(busy_ok), 64'd1);
              @(negedge clk);
              cnt++;
              chk("frame_done", 64'(fdone_w[g]), 64'd1);
              chk("frame_count", 64'(fc_w[g]), 64'(cnt));
              chk("busy_after_frame", 64'(busy_w[g]), 64'd0);
              gap = 1;
            end
          end
        end
      end
    end
  end

  task automatic idle_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_drain(input int i, input string nm);
    int n;
    n = 0;
    while ((eq[i].size() != 0 || fq[i].size() != 0 || busy_w[i]) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_drain_timeout"}, 64'(n < 400), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int i, input string nm);
    int n;
    n = 0;
    while (!rd_w[i] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_pop_timeout"}, 64'(n < 50), 64'd1);
  endtask

  task automatic wait_idle(input int i, input string nm);
    int n;
    n = 0;
    while (busy_w[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_idle_timeout"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int bad;
    reset = 1'b0;
    en    = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx_w[0]), 64'd1);
    chk("rst_busy", 64'(busy_w[0]), 64'd0);
    chk("rst_rd_en", 64'(rd_w[0]), 64'd0);
    chk("rst_frame_done", 64'(fdone_w[0]), 64'd0);
    chk("rst_frame_count", 64'(fc_w[0]), 64'd0);
    reset = 1'b1;

    // T1: single byte 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    fq[0].push_back(8'hA5);
    push_exp(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
    p = gi[0].pops;
    en[0] = 1'b1;
    wait_drain(0, "t1");
    chk("t1_pops", 64'(gi[0].pops - p), 64'd1);
    chk("t1_frame_count", 64'(fc_w[0]), 64'd1);

    // T2: back-to-back 0x01, 0x80 with a 3-cycle idle gap
    idle_reset();
    fq[0].push_back(8'h01);
    fq[0].push_back(8'h80);
    push_exp(0, 16'({1'b1, 8'h01, 1'b0}), 10, -1);
    push_exp(0, 16'({1'b1, 8'h80, 1'b0}), 10, 3);
    p = gi[0].pops;
    wait_drain(0, "t2");
    chk("t2_pops", 64'(gi[0].pops - p), 64'd2);
    chk("t2_frame_count", 64'(fc_w[0]), 64'd2);
    chk("t2_fifo_empty", 64'(gi[0].fempty), 64'd1);

    // T3: empty FIFO for 100 cycles, then 0x3C and start-bit latency
    idle_reset();
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (rd_w[0] || !tx_w[0] || busy_w[0]) bad++;
    end
    chk("t3_empty_idle", 64'(bad), 64'd0);
    fq[0].push_back(8'h3C);
    push_exp(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
    @(posedge clk);
    #1;
    chk("t3_rd_en_first_edge", 64'(rd_w[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_tx_high_second_edge", 64'(tx_w[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_tx_low_third_edge", 64'(tx_w[0]), 64'd0);
    wait_drain(0, "t3");

    // T4: parity even (bit 0, 44 clocks) and parity odd with two stop bits (bit 1, 8-clock stop)
    fq[1].push_back(8'hA5);
    fq[2].push_back(8'hA5);
    push_exp(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, -1);
    push_exp(2, 16'({2'b11, 1'b1, 8'hA5, 1'b0}), 12, -1);
    en[1] = 1'b1;
    en[2] = 1'b1;
    wait_drain(1, "t4_even");
    wait_drain(2, "t4_odd");
    chk("t4_even_count", 64'(fc_w[1]), 64'd1);
    chk("t4_odd_count", 64'(fc_w[2]), 64'd1);

    // T5: drop en during data bit 3 of 0x55 with 0x66 queued
    idle_reset();
    fq[0].push_back(8'h55);
    fq[0].push_back(8'h66);
    push_exp(0, 16'({1'b1, 8'h55, 1'b0}), 10, -1);
    push_exp(0, 16'({1'b1, 8'h66, 1'b0}), 10, -1);
    p = gi[0].pops;
    wait_rd(0, "t5");
    repeat (19) @(posedge clk);
    #1;
    chk("t5_in_bit3", 64'(tx_w[0]), 64'd0);
    en[0] = 1'b0;
    wait_idle(0, "t5");
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_pop_while_off", 64'(gi[0].pops - p), 64'd1);
    chk("t5_byte_still_queued", 64'(fq[0].size()), 64'd1);
    chk("t5_idle_busy", 64'(busy_w[0]), 64'd0);
    en[0] = 1'b1;
    wait_drain(0, "t5");
    chk("t5_pops", 64'(gi[0].pops - p), 64'd2);
    chk("t5_frame_count", 64'(fc_w[0]), 64'd2);

    // T6: reset during data bit 5 of 0xF0; 0x42 follows after release
    idle_reset();
    fq[0].push_back(8'hF0);
    fq[0].push_back(8'h42);
    push_exp(0, 16'({1'b1, 8'h42, 1'b0}), 10, -1);
    p = gi[0].pops;
    wait_rd(0, "t6");
    repeat (27) @(posedge clk);
    #1;
    chk("t6_busy_before", 64'(busy_w[0]), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_tx", 64'(tx_w[0]), 64'd1);
    chk("t6_busy", 64'(busy_w[0]), 64'd0);
    chk("t6_frame_done", 64'(fdone_w[0]), 64'd0);
    chk("t6_frame_count", 64'(fc_w[0]), 64'd0);
    chk("t6_rd_en", 64'(rd_w[0]), 64'd0);
    reset = 1'b1;
    wait_drain(0, "t6");
    chk("t6_pops", 64'(gi[0].pops - p), 64'd2);
    chk("t6_frame_count_after", 64'(fc_w[0]), 64'd1);

    chk("leftover_expected", 64'(eq[0].size() + eq[1].size() + eq[2].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
